// File: rtl/bus_arbiter4.sv
// Four-requester round-robin arbiter with a bounded burst per grant.
// Drives the 4:1 bus mux select and registers the muxed word into a valid/ready stage.
module bus_arbiter4 #(
  parameter int unsigned N     = 16,
  parameter int unsigned BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [N-1:0] dbus,
  output logic [1:0]   sel,
  output logic [3:0]   gnt,
  output logic [3:0]   ack,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic             beat_c;
  logic [1:0]       winner_c;

  // First requester after ptr in circular order; ptr itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] c;
    logic [1:0] w;
    logic       f;
    w = p;
    f = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      c = p + 2'(k);
      if (!f && r[c]) begin
        w = c;
        f = 1'b1;
      end
    end
    return w;
  endfunction

  assign winner_c = rr_pick(req, ptr_q);
  assign beat_c   = (state_q == BUSY) && req[owner_q] && (!out_valid_q || out_ready);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    // Output stage: a beat overwrites (and so also covers a same-cycle pop).
    if (beat_c) begin
      out_data_d  = dbus;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          state_d = BUSY;
          owner_d = winner_c;
          sel_d   = winner_c;
          gnt_d   = 4'b0001 << winner_c;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (!req[owner_q] || (beat_c && cnt_q == LAST_BEAT)) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = owner_q;
          cnt_d   = '0;
        end else if (beat_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      ptr_q       <= 2'd3;
      cnt_q       <= '0;
      sel_q       <= 2'd0;
      gnt_q       <= 4'b0000;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign ack       = beat_c ? gnt_q : 4'b0000;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule
